// File: rtl/phys_reg_pkg.sv
// Shared defaults and helpers for the physical register file and its ready scoreboard.
// Address width derivation and constant-register values live here so both blocks agree.
package phys_reg_pkg;

    localparam int DEF_NUM_PREGS = 32;
    localparam int DEF_DATA_W    = 8;
    localparam int DEF_NUM_RD    = 12;
    localparam int DEF_NUM_WR    = 6;
    localparam int DEF_NUM_ALLOC = 2;
    localparam int DEF_NUM_CONST = 2;
    localparam int DEF_BYPASS    = 1;

    // At least one address bit, even for a degenerate single-entry file.
    function automatic int addr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Constant registers read back their own index.
    function automatic int const_val(input int idx);
        return idx;
    endfunction

    // True for addresses backed by flops: neither constant nor out of range.
    function automatic logic is_data_reg(input int addr, input int num_const, input int num_pregs);
        return (addr >= num_const) && (addr < num_pregs);
    endfunction

endpackage

// File: rtl/preg_ready_table.sv
// Ready-bit scoreboard: one bit per physical register.
// Per-register priority is flush (set) over alloc (clear) over writeback (set) over hold.
module preg_ready_table
    import phys_reg_pkg::*;
#(
    parameter int NUM_PREGS = DEF_NUM_PREGS,
    parameter int NUM_WR    = DEF_NUM_WR,
    parameter int NUM_ALLOC = DEF_NUM_ALLOC,
    parameter int NUM_CONST = DEF_NUM_CONST,
    localparam int AW       = addr_w(NUM_PREGS)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_WR-1:0]       wr_en,
    input  logic [NUM_WR*AW-1:0]    wr_addr,
    input  logic [NUM_ALLOC-1:0]    alloc_en,
    input  logic [NUM_ALLOC*AW-1:0] alloc_addr,
    input  logic                    flush,
    output logic [NUM_PREGS-1:0]    ready
);

    logic [NUM_PREGS-1:0] ready_d;

    // Later assignments override earlier ones, which encodes the priority order.
    always_comb begin
        // NOTE: start from the held value so every path assigns ready_d and no latch is inferred.
        ready_d = ready;
        for (int i = 0; i < NUM_WR; i++) begin
            if (wr_en[i] && is_data_reg(int'(wr_addr[i*AW +: AW]), NUM_CONST, NUM_PREGS))
                ready_d[wr_addr[i*AW +: AW]] = 1'b1;
        end
        for (int j = 0; j < NUM_ALLOC; j++) begin
            if (alloc_en[j] && is_data_reg(int'(alloc_addr[j*AW +: AW]), NUM_CONST, NUM_PREGS))
                ready_d[alloc_addr[j*AW +: AW]] = 1'b0;
        end
        if (flush)
            ready_d = '1;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            ready <= '1;
        else
            ready <= ready_d;
    end

endmodule

// File: rtl/phys_reg_file_sb.sv
// Physical register file with integrated ready scoreboard for the out-of-order 6502 core.
// Combinational multi-port read with optional same-cycle writeback forwarding.
module phys_reg_file_sb
    import phys_reg_pkg::*;
#(
    parameter int NUM_PREGS = DEF_NUM_PREGS,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int NUM_RD    = DEF_NUM_RD,
    parameter int NUM_WR    = DEF_NUM_WR,
    parameter int NUM_ALLOC = DEF_NUM_ALLOC,
    parameter int NUM_CONST = DEF_NUM_CONST,
    parameter int BYPASS    = DEF_BYPASS,
    localparam int AW       = addr_w(NUM_PREGS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_RD*AW-1:0]      rd_addr,
    output logic [NUM_RD*DATA_W-1:0]  rd_data,
    output logic [NUM_RD-1:0]         rd_ready,
    input  logic [NUM_WR-1:0]         wr_en,
    input  logic [NUM_WR*AW-1:0]      wr_addr,
    input  logic [NUM_WR*DATA_W-1:0]  wr_data,
    input  logic [NUM_ALLOC-1:0]      alloc_en,
    input  logic [NUM_ALLOC*AW-1:0]   alloc_addr,
    input  logic                      flush
);

    localparam int NUM_DATA = NUM_PREGS - NUM_CONST;
    localparam int IW       = addr_w(NUM_DATA);

    logic [DATA_W-1:0]    mem [NUM_DATA];
    logic [NUM_PREGS-1:0] ready;
    logic [NUM_WR-1:0]    wr_ok;
    logic [IW-1:0]        wr_idx [NUM_WR];

    preg_ready_table #(
        .NUM_PREGS (NUM_PREGS),
        .NUM_WR    (NUM_WR),
        .NUM_ALLOC (NUM_ALLOC),
        .NUM_CONST (NUM_CONST)
    ) u_ready (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .alloc_en   (alloc_en),
        .alloc_addr (alloc_addr),
        .flush      (flush),
        .ready      (ready)
    );

    // Constant and out-of-range writes are filtered here; storage is indexed past the constants.
    always_comb begin
        for (int i = 0; i < NUM_WR; i++) begin
            wr_ok[i]  = wr_en[i] && is_data_reg(int'(wr_addr[i*AW +: AW]), NUM_CONST, NUM_PREGS);
            wr_idx[i] = IW'(int'(wr_addr[i*AW +: AW]) - NUM_CONST);
        end
    end

    // Ascending port order makes the highest-indexed writer the last assignment, so it wins.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: the array is reset on purpose; a cleared file must read zero right after reset.
            for (int j = 0; j < NUM_DATA; j++)
                mem[j] <= '0;
        end else begin
            for (int i = 0; i < NUM_WR; i++) begin
                if (wr_ok[i])
                    mem[wr_idx[i]] <= wr_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Forwarding is held off during reset so reads show reset values, not pending writes.
    always_comb begin
        rd_data  = '0;
        rd_ready = '1;
        for (int k = 0; k < NUM_RD; k++) begin
            if (int'(rd_addr[k*AW +: AW]) < NUM_CONST) begin
                rd_data[k*DATA_W +: DATA_W] = DATA_W'(const_val(int'(rd_addr[k*AW +: AW])));
            end else if (int'(rd_addr[k*AW +: AW]) < NUM_PREGS) begin
                rd_data[k*DATA_W +: DATA_W] = mem[IW'(int'(rd_addr[k*AW +: AW]) - NUM_CONST)];
                rd_ready[k]                 = ready[rd_addr[k*AW +: AW]];
            end
            if (BYPASS != 0 && rst) begin
                for (int i = 0; i < NUM_WR; i++) begin
                    if (wr_ok[i] && wr_addr[i*AW +: AW] == rd_addr[k*AW +: AW]) begin
                        rd_data[k*DATA_W +: DATA_W] = wr_data[i*DATA_W +: DATA_W];
                        rd_ready[k]                 = 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_phys_reg_file_sb.sv
// Directed bench for phys_reg_file_sb: bypass and non-bypass copies share stimulus,
// plus a wide-parameter instance for the sweep scenario.
module tb_phys_reg_file_sb;

    logic clk;
    logic rst;

    logic [59:0] rd_addr;
    logic [95:0] rd_data_a, rd_data_b;
    logic [11:0] rd_ready_a, rd_ready_b;
    logic [5:0]  wr_en;
    logic [29:0] wr_addr;
    logic [47:0] wr_data;
    logic [1:0]  alloc_en;
    logic [9:0]  alloc_addr;
    logic        flush;

    logic [23:0] c_rd_addr;
    logic [63:0] c_rd_data;
    logic [3:0]  c_rd_ready;
    logic [1:0]  c_wr_en;
    logic [11:0] c_wr_addr;
    logic [31:0] c_wr_data;
    logic [1:0]  c_alloc_en;
    logic [11:0] c_alloc_addr;
    logic        c_flush;

    int tests_run;
    int tests_failed;

    phys_reg_file_sb #(.BYPASS(1)) dut_a (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_a), .rd_ready(rd_ready_a),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .alloc_en(alloc_en), .alloc_addr(alloc_addr), .flush(flush)
    );

    phys_reg_file_sb #(.BYPASS(0)) dut_b (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_ready(rd_ready_b),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .alloc_en(alloc_en), .alloc_addr(alloc_addr), .flush(flush)
    );

    phys_reg_file_sb #(
        .NUM_PREGS(64), .DATA_W(16), .NUM_RD(4), .NUM_WR(2), .NUM_ALLOC(2), .NUM_CONST(1), .BYPASS(1)
    ) dut_c (
        .clk(clk), .rst(rst), .rd_addr(c_rd_addr), .rd_data(c_rd_data), .rd_ready(c_rd_ready),
        .wr_en(c_wr_en), .wr_addr(c_wr_addr), .wr_data(c_wr_data),
        .alloc_en(c_alloc_en), .alloc_addr(c_alloc_addr), .flush(c_flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        wr_en = '0; wr_addr = '0; wr_data = '0;
        alloc_en = '0; alloc_addr = '0; flush = 1'b0;
        c_wr_en = '0; c_wr_addr = '0; c_wr_data = '0;
        c_alloc_en = '0; c_alloc_addr = '0; c_flush = 1'b0;
    endtask

    task automatic set_rd(input int k, input logic [4:0] a);
        rd_addr[k*5 +: 5] = a;
    endtask

    task automatic set_wr(input int i, input logic [4:0] a, input logic [7:0] d);
        wr_en[i] = 1'b1;
        wr_addr[i*5 +: 5] = a;
        wr_data[i*8 +: 8] = d;
    endtask

    task automatic set_alloc(input int j, input logic [4:0] a);
        alloc_en[j] = 1'b1;
        alloc_addr[j*5 +: 5] = a;
    endtask

    function automatic logic [7:0] a_data(input int k);
        return rd_data_a[k*8 +: 8];
    endfunction

    function automatic logic [7:0] b_data(input int k);
        return rd_data_b[k*8 +: 8];
    endfunction

    function automatic logic [15:0] c_data(input int k);
        return c_rd_data[k*16 +: 16];
    endfunction

    task automatic test_reset();
        step();
        set_wr(0, 5'd5, 8'h33);
        step();
        clear_inputs();
        set_rd(0, 5'd5);
        set_rd(1, 5'd1);
        #1;
        tests_run++;
        if (a_data(0) !== 8'h33) begin
            tests_failed++; $display("FAIL pre_reset_p5: got %h want %h", a_data(0), 8'h33);
        end
        // Pending write, then reset asserted mid-cycle.
        set_wr(0, 5'd5, 8'h77);
        #2 rst = 1'b0;
        #1;
        tests_run++;
        if (rd_ready_a !== 12'hFFF) begin
            tests_failed++; $display("FAIL reset_ready_a: got %h want %h", rd_ready_a, 12'hFFF);
        end
        tests_run++;
        if (rd_ready_b !== 12'hFFF) begin
            tests_failed++; $display("FAIL reset_ready_b: got %h want %h", rd_ready_b, 12'hFFF);
        end
        tests_run++;
        if (a_data(0) !== 8'h00) begin
            tests_failed++; $display("FAIL reset_p5_a: got %h want %h", a_data(0), 8'h00);
        end
        tests_run++;
        if (b_data(0) !== 8'h00) begin
            tests_failed++; $display("FAIL reset_p5_b: got %h want %h", b_data(0), 8'h00);
        end
        tests_run++;
        if (a_data(1) !== 8'h01) begin
            tests_failed++; $display("FAIL reset_const_p1: got %h want %h", a_data(1), 8'h01);
        end
        step();
        clear_inputs();
        rst = 1'b1;
        #1;
        tests_run++;
        if (b_data(0) !== 8'h00 || a_data(0) !== 8'h00) begin
            tests_failed++; $display("FAIL reset_write_dropped: got a=%h b=%h want 00", a_data(0), b_data(0));
        end
    endtask

    task automatic test_write_read();
        step();
        set_wr(0, 5'd7, 8'hA5);
        set_rd(0, 5'd7);
        #1;
        tests_run++;
        if (a_data(0) !== 8'hA5 || rd_ready_a[0] !== 1'b1) begin
            tests_failed++; $display("FAIL bypass_same_cycle: got %h/%b want a5/1", a_data(0), rd_ready_a[0]);
        end
        tests_run++;
        if (b_data(0) !== 8'h00) begin
            tests_failed++; $display("FAIL nobypass_same_cycle: got %h want %h", b_data(0), 8'h00);
        end
        step();
        clear_inputs();
        #1;
        tests_run++;
        if (a_data(0) !== 8'hA5 || b_data(0) !== 8'hA5 || rd_ready_b[0] !== 1'b1) begin
            tests_failed++;
            $display("FAIL write_next_cycle: got a=%h b=%h rdy=%b want a5 a5 1", a_data(0), b_data(0), rd_ready_b[0]);
        end
    endtask

    task automatic test_conflict();
        step();
        set_wr(1, 5'd9, 8'h11);
        set_wr(4, 5'd9, 8'h44);
        set_wr(2, 5'd0, 8'hFF);
        set_rd(0, 5'd9);
        set_rd(1, 5'd0);
        #1;
        tests_run++;
        if (a_data(0) !== 8'h44) begin
            tests_failed++; $display("FAIL conflict_bypass: got %h want %h", a_data(0), 8'h44);
        end
        step();
        clear_inputs();
        #1;
        tests_run++;
        if (a_data(0) !== 8'h44 || b_data(0) !== 8'h44) begin
            tests_failed++; $display("FAIL conflict_commit: got a=%h b=%h want 44", a_data(0), b_data(0));
        end
        tests_run++;
        if (a_data(1) !== 8'h00 || rd_ready_a[1] !== 1'b1) begin
            tests_failed++; $display("FAIL const_p0_write: got %h/%b want 00/1", a_data(1), rd_ready_a[1]);
        end
    endtask

    task automatic test_scoreboard();
        step();
        set_alloc(0, 5'd12);
        set_rd(0, 5'd12);
        #1;
        tests_run++;
        if (rd_ready_a[0] !== 1'b1) begin
            tests_failed++; $display("FAIL alloc_not_bypassed: got %b want 1", rd_ready_a[0]);
        end
        step();
        clear_inputs();
        #1;
        tests_run++;
        if (rd_ready_a[0] !== 1'b0 || rd_ready_b[0] !== 1'b0) begin
            tests_failed++; $display("FAIL alloc_clears: got a=%b b=%b want 0", rd_ready_a[0], rd_ready_b[0]);
        end
        set_wr(3, 5'd12, 8'h3C);
        #1;
        tests_run++;
        if (rd_ready_a[0] !== 1'b1 || rd_ready_b[0] !== 1'b0) begin
            tests_failed++; $display("FAIL wb_ready_same_cycle: got a=%b b=%b want 1 0", rd_ready_a[0], rd_ready_b[0]);
        end
        step();
        clear_inputs();
        #1;
        tests_run++;
        if (rd_ready_b[0] !== 1'b1 || b_data(0) !== 8'h3C) begin
            tests_failed++; $display("FAIL wb_sets_ready: got %b/%h want 1/3c", rd_ready_b[0], b_data(0));
        end
        set_alloc(1, 5'd12);
        set_wr(0, 5'd12, 8'h5A);
        step();
        clear_inputs();
        #1;
        tests_run++;
        if (rd_ready_b[0] !== 1'b0 || rd_ready_a[0] !== 1'b0) begin
            tests_failed++; $display("FAIL alloc_over_wb_ready: got a=%b b=%b want 0", rd_ready_a[0], rd_ready_b[0]);
        end
        tests_run++;
        if (b_data(0) !== 8'h5A) begin
            tests_failed++; $display("FAIL alloc_wb_data: got %h want %h", b_data(0), 8'h5A);
        end
    endtask

    task automatic test_flush();
        step();
        set_alloc(0, 5'd3);
        set_alloc(1, 5'd4);
        step();
        clear_inputs();
        set_alloc(0, 5'd5);
        step();
        clear_inputs();
        set_rd(0, 5'd3);
        set_rd(1, 5'd4);
        set_rd(2, 5'd5);
        set_rd(3, 5'd6);
        #1;
        tests_run++;
        if (rd_ready_b[3:0] !== 4'b1000) begin
            tests_failed++; $display("FAIL pre_flush_ready: got %b want %b", rd_ready_b[3:0], 4'b1000);
        end
        flush = 1'b1;
        set_alloc(0, 5'd6);
        step();
        clear_inputs();
        #1;
        tests_run++;
        if (rd_ready_b[3:0] !== 4'hF || rd_ready_a[3:0] !== 4'hF) begin
            tests_failed++; $display("FAIL flush_ready: got a=%b b=%b want 1111", rd_ready_a[3:0], rd_ready_b[3:0]);
        end
    endtask

    task automatic test_param_sweep();
        step();
        c_rd_addr[0 +: 6]  = 6'd63;
        c_rd_addr[6 +: 6]  = 6'd1;
        c_rd_addr[12 +: 6] = 6'd0;
        #1;
        tests_run++;
        if (c_data(1) !== 16'h0000) begin
            tests_failed++; $display("FAIL sweep_p1_reset: got %h want %h", c_data(1), 16'h0000);
        end
        c_wr_en = 2'b11;
        c_wr_addr = {6'd63, 6'd1};
        c_wr_data = {16'hBEEF, 16'h1234};
        #1;
        tests_run++;
        if (c_data(0) !== 16'hBEEF) begin
            tests_failed++; $display("FAIL sweep_bypass_p63: got %h want %h", c_data(0), 16'hBEEF);
        end
        step();
        clear_inputs();
        #1;
        tests_run++;
        if (c_data(0) !== 16'hBEEF) begin
            tests_failed++; $display("FAIL sweep_p63: got %h want %h", c_data(0), 16'hBEEF);
        end
        tests_run++;
        if (c_data(1) !== 16'h1234) begin
            tests_failed++; $display("FAIL sweep_p1_stored: got %h want %h", c_data(1), 16'h1234);
        end
        tests_run++;
        if (c_data(2) !== 16'h0000 || c_rd_ready[2:0] !== 3'b111) begin
            tests_failed++; $display("FAIL sweep_p0_const: got %h/%b want 0000/111", c_data(2), c_rd_ready[2:0]);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rd_addr   = '0;
        c_rd_addr = '0;
        clear_inputs();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        test_reset();
        test_write_read();
        test_conflict();
        test_scoreboard();
        test_flush();
        test_param_sweep();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/phys_reg_file_sb.md
# phys_reg_file_sb

Parametrised physical register file with integrated ready scoreboard for the out-of-order 6502 core. It holds renamed register values between rename/dispatch and writeback. It also tracks per-register ready bits: rename allocation clears them, writeback sets them, flush forces them. Reads expose both value and ready state to the issue queues, with optional same-cycle write-to-read bypass. Constant registers hold their own index value, so physical 0 reads 0x00 and physical 1 reads 0x01 when NUM_CONST=2.

## Interface
- NUM_PREGS, 32: physical registers including constants; address width AW = $clog2(NUM_PREGS)
- DATA_W, 8: register width
- NUM_RD, 12: read ports
- NUM_WR, 6: write (writeback) ports
- NUM_ALLOC, 2: allocation ports from rename
- NUM_CONST, 2: low-index constant registers; register k (k < NUM_CONST) always reads value k
- BYPASS, 1: 1 = same-cycle writeback forwarded to reads; 0 = reads see only registered state
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset; one clock; asynchronous, active-low
- rd_addr  in  NUM_RD*AW  packed read addresses, port k at [k*AW +: AW]
- rd_data  out  NUM_RD*DATA_W  read values
- rd_ready  out  NUM_RD  ready bit of each read address
- wr_en  in  NUM_WR  write enables
- wr_addr  in  NUM_WR*AW  write addresses
- wr_data  in  NUM_WR*DATA_W  write values
- alloc_en  in  NUM_ALLOC  allocate (mark not-ready) enables
- alloc_addr  in  NUM_ALLOC*AW  allocated physical registers
- flush  in  1  pipeline flush: all ready bits set next cycle

## Operation
- Storage covers NUM_PREGS-NUM_CONST data registers plus NUM_PREGS ready bits; constants have no flops.
- Read path is combinational.
  - Constant address k returns value k with ready=1.
  - Address >= NUM_PREGS returns 0 with ready=1.
  - Otherwise the port returns the stored value and ready bit.
- Bypass (BYPASS=1): if any wr_en[i] has wr_addr[i]==rd_addr[k] and the address is non-constant, rd_data[k] = wr_data of the highest matching i, and rd_ready[k] = 1.
- Write: each enabled port with non-constant, in-range address updates data and sets the ready bit. Constant or out-of-range writes are dropped silently.
- Write conflict: several ports writing the same address in one cycle → the highest port index wins.
- Allocation: each enabled alloc port with non-constant address clears that ready bit; data is unchanged. Allocation of a constant is ignored.
- Ready-bit priority per register, highest first: flush (set) > alloc (clear) > write (set) > hold. Data is still written when a write coincides with alloc or flush.
- rst asserted: all data registers → 0 and all ready bits → 1, asynchronously.
  - rst takes effect mid-cycle regardless of pending enables.
  - Outputs reflect reset values while rst is asserted: rd_data = 0 for non-constant addresses (constants still k), rd_ready = all 1.

## Timing
- Write latency: data visible on read 1 cycle after the write edge. With BYPASS=1 it is visible combinationally in the same cycle.
- Alloc latency: rd_ready drops the cycle after the alloc edge. It is not bypassed: a read in the same cycle as alloc sees the old ready bit.
- Flush latency: all ready bits are 1 from the cycle after the flush edge.
- No handshakes; every enable is single-cycle and sampled at the rising edge.
- Reset release: the first edge with rst high performs normal updates.

## Structure
- Package phys_reg_pkg holds default parameter values, the AW derivation function, and the constant-register value function (value = index).
- Sub-module preg_ready_table holds the NUM_PREGS ready-bit scoreboard with alloc/write/flush priority. The data array and bypass muxing stay in the top module.

## Test plan
- Reset: assert rst mid-cycle with wr_en set → all rd_ready=1; rd_addr=5 reads 0x00; rd_addr=1 reads 0x01; the pending write is not committed.
- Write/read: write 0xA5 to p7 → next cycle rd_addr=7 returns 0xA5, ready=1. With BYPASS=1 it returns 0xA5 in the write cycle; with BYPASS=0 it returns 0x00 in that cycle.
- Conflict: ports 1 and 4 both write p9 (0x11, 0x44) → p9 reads 0x44. A write to p0 of 0xFF → p0 still reads 0x00.
- Scoreboard: alloc p12 → next cycle rd_ready=0. Write 0x3C to p12 → ready=1 and data 0x3C. Alloc plus write to p12 in the same cycle → ready=0, data updated.
- Flush: alloc p3, p4, p5, then assert flush together with alloc p6 → next cycle all four ready=1.
- Parameter sweep: NUM_PREGS=64, DATA_W=16, NUM_RD=4, NUM_WR=2, NUM_CONST=1 → a write of 0xBEEF to p63 reads back 0xBEEF; rd_addr=1 reads stored data (not constant).
